// File: rtl/dual_port_bram.sv
// +----------------------------------------------------------------------------+
// | Module   : dual_port_bram                                                  |
// | Brief    : Two-port word RAM with PicoRV32-style handshakes, byte enables, |
// |            range checking and a same-word write collision stall on port B. |
// |            Port B is built only when DUAL_PORT_BRAM_BPORT_EN is defined.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module dual_port_bram_port #(
  parameter int          MEM_SIZE_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          READ_LATENCY   = 1,
  parameter int          AW             = 11
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_valid,
  input  logic [31:0]   i_addr,
  input  logic          i_stall,
  input  logic [31:0]   i_word,
  output logic          o_acc,
  output logic [AW-1:0] o_idx,
  output logic          o_inrange,
  output logic          o_ready,
  output logic [31:0]   o_rdata,
  output logic          o_err
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_PIPE = 2'd2,
    S_DONE = 2'd3
  } t_state;

  t_state      r_state, w_next;
  logic [31:0] w_off, w_word, r_pipe, r_rdata;
  logic        r_oor, r_pipe_oor, r_err;
  logic        w_unused;

  assign w_off     = i_addr - BASE_ADDR;
  assign o_inrange = (i_addr >= BASE_ADDR) && (w_off[31:AW+2] == '0);
  assign o_idx     = w_off[AW+1:2];
  assign o_acc     = resetn && (r_state == S_IDLE) && i_valid && !i_stall;
  assign w_word    = r_oor ? 32'hDEADBEEF : i_word;
  assign w_unused  = ^w_off[1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (o_acc) w_next = S_ACC;
      S_ACC:   w_next = (READ_LATENCY == 2) ? S_PIPE : S_DONE;
      S_PIPE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (o_acc) r_oor <= !o_inrange;
    if (r_state == S_ACC) begin
      r_pipe     <= w_word;
      r_pipe_oor <= r_oor;
    end
  end

  // rdata/err only change on the way into DONE so they hold between completions
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if ((w_next == S_DONE) && (r_state != S_DONE)) begin
      r_rdata <= (READ_LATENCY == 2) ? r_pipe : w_word;
      r_err   <= (READ_LATENCY == 2) ? r_pipe_oor : r_oor;
    end
  end

  assign o_ready = (r_state == S_DONE);
  assign o_err   = o_ready && r_err;
  assign o_rdata = r_rdata;
endmodule

module dual_port_bram #(
  parameter int          MEM_SIZE_WORDS = 2048,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          READ_LATENCY   = 1,
  parameter string       MEM_INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        a_valid,
  input  logic        a_instr,
  output logic        a_ready,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  input  logic [3:0]  a_wstrb,
  output logic [31:0] a_rdata,
  output logic        a_err,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  input  logic [3:0]  b_wstrb,
  output logic [31:0] b_rdata,
  output logic        b_err
);
  localparam int          AW    = $clog2(MEM_SIZE_WORDS);
  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic [31:0]   r_mem [MEM_SIZE_WORDS];
  logic [31:0]   r_a_word;
  logic          w_a_acc, w_a_inr;
  logic [AW-1:0] w_a_idx;
  logic          w_unused;

  initial begin
    for (int i = 0; i < MEM_SIZE_WORDS; i++) r_mem[i] = c_NOP;
  end

  dual_port_bram_port #(
    .MEM_SIZE_WORDS(MEM_SIZE_WORDS), .BASE_ADDR(BASE_ADDR),
    .READ_LATENCY(READ_LATENCY), .AW(AW)
  ) u_port_a (
    .clk(clk), .resetn(resetn), .i_valid(a_valid), .i_addr(a_addr),
    .i_stall(1'b0), .i_word(r_a_word), .o_acc(w_a_acc), .o_idx(w_a_idx),
    .o_inrange(w_a_inr), .o_ready(a_ready), .o_rdata(a_rdata), .o_err(a_err)
  );

`ifdef DUAL_PORT_BRAM_BPORT_EN
  logic [31:0]   r_b_word;
  logic          w_b_acc, w_b_inr, w_b_stall;
  logic [AW-1:0] w_b_idx;

  // A wins a same-word access whenever either side writes; B retries next cycle
  assign w_b_stall = w_a_acc && w_a_inr && w_b_inr && (w_a_idx == w_b_idx) &&
                     ((a_wstrb | b_wstrb) != 4'b0000);

  dual_port_bram_port #(
    .MEM_SIZE_WORDS(MEM_SIZE_WORDS), .BASE_ADDR(BASE_ADDR),
    .READ_LATENCY(READ_LATENCY), .AW(AW)
  ) u_port_b (
    .clk(clk), .resetn(resetn), .i_valid(b_valid), .i_addr(b_addr),
    .i_stall(w_b_stall), .i_word(r_b_word), .o_acc(w_b_acc), .o_idx(w_b_idx),
    .o_inrange(w_b_inr), .o_ready(b_ready), .o_rdata(b_rdata), .o_err(b_err)
  );

  assign w_unused = a_instr;
`else
  assign b_ready  = 1'b0;
  assign b_err    = 1'b0;
  assign b_rdata  = '0;
  assign w_unused = ^{a_instr, b_valid, b_addr, b_wdata, b_wstrb};
`endif

  always_ff @(posedge clk) begin
    if (w_a_acc) begin
      r_a_word <= r_mem[w_a_idx];
      if (w_a_inr) begin
        if (a_wstrb[0]) r_mem[w_a_idx][7:0]   <= a_wdata[7:0];
        if (a_wstrb[1]) r_mem[w_a_idx][15:8]  <= a_wdata[15:8];
        if (a_wstrb[2]) r_mem[w_a_idx][23:16] <= a_wdata[23:16];
        if (a_wstrb[3]) r_mem[w_a_idx][31:24] <= a_wdata[31:24];
      end
    end
`ifdef DUAL_PORT_BRAM_BPORT_EN
    if (w_b_acc) begin
      r_b_word <= r_mem[w_b_idx];
      if (w_b_inr) begin
        if (b_wstrb[0]) r_mem[w_b_idx][7:0]   <= b_wdata[7:0];
        if (b_wstrb[1]) r_mem[w_b_idx][15:8]  <= b_wdata[15:8];
        if (b_wstrb[2]) r_mem[w_b_idx][23:16] <= b_wdata[23:16];
        if (b_wstrb[3]) r_mem[w_b_idx][31:24] <= b_wdata[31:24];
      end
    end
`endif
  end
endmodule

`default_nettype wire

// File: tb/tb_dual_port_bram.sv
// +----------------------------------------------------------------------------+
// | Module   : tb_dual_port_bram                                               |
// | Brief    : Directed and random checks of dual_port_bram against a word     |
// |            array model; a second instance exercises READ_LATENCY=2.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_dual_port_bram;
`ifdef DUAL_PORT_BRAM_BPORT_EN
  localparam bit B_EN = 1'b1;
`else
  localparam bit B_EN = 1'b0;
`endif

  logic        clk = 1'b0, resetn = 1'b0;
  logic        a_valid = 0, a_instr = 0, b_valid = 0;
  logic [31:0] a_addr = 0, a_wdata = 0, b_addr = 0, b_wdata = 0;
  logic [3:0]  a_wstrb = 0, b_wstrb = 0;
  logic        a_ready, a_err, b_ready, b_err;
  logic [31:0] a_rdata, b_rdata;

  logic        l2_a_valid = 0, l2_b_valid = 0;
  logic [31:0] l2_a_addr = 0, l2_zero32 = 0;
  logic [3:0]  l2_zero4 = 0;
  logic        l2_a_ready, l2_a_err, l2_b_ready, l2_b_err;
  logic [31:0] l2_a_rdata, l2_b_rdata;

  logic [31:0] model_mem [2048];
  int n_checks = 0, n_errors = 0;

  always #5 clk = ~clk;

  dual_port_bram u_dut (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_instr(a_instr), .a_ready(a_ready), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_wstrb(a_wstrb), .a_rdata(a_rdata), .a_err(a_err),
    .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_wstrb(b_wstrb), .b_rdata(b_rdata), .b_err(b_err)
  );

  dual_port_bram #(.READ_LATENCY(2)) u_dut_l2 (
    .clk(clk), .resetn(resetn),
    .a_valid(l2_a_valid), .a_instr(1'b0), .a_ready(l2_a_ready), .a_addr(l2_a_addr),
    .a_wdata(l2_zero32), .a_wstrb(l2_zero4), .a_rdata(l2_a_rdata), .a_err(l2_a_err),
    .b_valid(l2_b_valid), .b_ready(l2_b_ready), .b_addr(l2_zero32), .b_wdata(l2_zero32),
    .b_wstrb(l2_zero4), .b_rdata(l2_b_rdata), .b_err(l2_b_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: read-first word access on a 2048-word window at address 0
  task automatic model_access(input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] strb, output logic [31:0] rd,
                              output logic err);
    logic [31:0] w;
    if (addr < 32'h2000) begin
      rd = model_mem[addr[12:2]];
      err = 1'b0;
      w = rd;
      for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
      model_mem[addr[12:2]] = w;
    end else begin
      rd = 32'hDEADBEEF;
      err = 1'b1;
    end
  endtask

  task automatic run_txn(input bit a_en, input logic [31:0] aa, input logic [31:0] aw,
                         input logic [3:0] as, input bit b_en, input logic [31:0] ba,
                         input logic [31:0] bw, input logic [3:0] bs,
                         output logic [31:0] a_got);
    logic [31:0] ea, eb;
    logic        eae, ebe;
    int          la, lb, cyc;
    bit          ad, bd, coll;
    ea = 0; eb = 0; eae = 0; ebe = 0; a_got = 0;
    coll = B_EN && a_en && b_en && (aa < 32'h2000) && (ba < 32'h2000) &&
           (aa[12:2] == ba[12:2]) && ((as | bs) != 4'b0);
    if (a_en) model_access(aa, aw, as, ea, eae);
    if (b_en && B_EN) model_access(ba, bw, bs, eb, ebe);
    la = 2;
    lb = coll ? 3 : 2;
    @(negedge clk);
    a_valid = a_en; a_addr = aa; a_wdata = aw; a_wstrb = as;
    b_valid = b_en; b_addr = ba; b_wdata = bw; b_wstrb = bs;
    ad = !a_en; bd = !(b_en && B_EN); cyc = 0;
    while (!(ad && bd) && cyc < 12) begin
      @(posedge clk); #1; cyc++;
      if (ad) check_eq("a_idle_ready", 32'(a_ready), 0);
      else if (a_ready) begin
        check_eq("a_latency", 32'(cyc), 32'(la));
        check_eq("a_rdata", a_rdata, ea);
        check_eq("a_err", 32'(a_err), 32'(eae));
        a_got = a_rdata; ad = 1; a_valid = 0;
      end
      if (bd) check_eq("b_idle_ready", 32'(b_ready), 0);
      else if (b_ready) begin
        check_eq("b_latency", 32'(cyc), 32'(lb));
        check_eq("b_rdata", b_rdata, eb);
        check_eq("b_err", 32'(b_err), 32'(ebe));
        bd = 1; b_valid = 0;
      end
    end
    check_eq("txn_completed", {30'b0, ad, bd}, 32'd3);
    a_valid = 0; b_valid = 0;
    @(posedge clk); #1;
    check_eq("ready_one_cycle", {30'b0, a_ready, b_ready}, 0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)       return {19'b0, 11'($urandom_range(0, 7)), 2'($urandom)};
    else if (r < 8)  return {19'b0, 11'($urandom), 2'($urandom)};
    else if (r == 8) return 32'h2000 + {20'b0, 10'($urandom), 2'b00};
    else             return 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
  endfunction

  initial begin
    logic [31:0] got, rd;
    logic        e;
    for (int i = 0; i < 2048; i++) model_mem[i] = 32'h0000_0013;

    // reset values
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_a_ready", 32'(a_ready), 0);
    check_eq("rst_b_ready", 32'(b_ready), 0);
    check_eq("rst_errs", {30'b0, a_err, b_err}, 0);
    check_eq("rst_a_rdata", a_rdata, 0);
    check_eq("rst_b_rdata", b_rdata, 0);
    check_eq("rst_l2_ready", 32'(l2_a_ready), 0);
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;

    run_txn(1, 32'h10, 0, 4'h0, 0, 0, 0, 0, got);
    check_eq("default_nop", got, 32'h0000_0013);

    // valid held through DONE: next accept is one cycle after the ready cycle
    @(negedge clk);
    a_valid = 1; a_addr = 32'h10; a_wstrb = 0;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      check_eq("hold_l1_ready", 32'(a_ready), 32'((c % 3) == 2));
      if (a_ready) check_eq("hold_l1_rdata", a_rdata, model_mem[4]);
    end
    a_valid = 0;
    @(negedge clk);
    l2_a_valid = 1; l2_a_addr = 32'h10;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      check_eq("hold_l2_ready", 32'(l2_a_ready), 32'((c % 4) == 3));
      if (l2_a_ready) check_eq("hold_l2_rdata", l2_a_rdata, 32'h0000_0013);
    end
    l2_a_valid = 0;
    @(posedge clk); #1;

    run_txn(1, 32'h20, 32'h1122_3344, 4'hF, 0, 0, 0, 0, got);
    run_txn(1, 32'h20, 32'hAABB_CCDD, 4'b0101, 0, 0, 0, 0, got);
    run_txn(1, 32'h20, 0, 4'h0, 0, 0, 0, 0, got);
    check_eq("byte_merge", got, 32'h11BB_33DD);

    run_txn(1, 32'h30, 32'h1111_1111, 4'hF, 1, 32'h30, 32'h2222_2222, 4'hF, got);
    check_eq("coll_a_old", got, 32'h0000_0013);
    run_txn(1, 32'h30, 0, 4'h0, 0, 0, 0, 0, got);
    check_eq("coll_final", got, B_EN ? 32'h2222_2222 : 32'h1111_1111);

    run_txn(1, 32'h24, 0, 4'h0, 1, 32'h24, 0, 4'h0, got);
    run_txn(0, 0, 0, 0, 1, 32'h2000, 32'h5555_5555, 4'hF, got);
    run_txn(1, 32'h0, 0, 4'h0, 0, 0, 0, 0, got);
    check_eq("oor_no_alias", got, 32'h0000_0013);

    // reset during ACC of a write: no ready, write persists
    @(negedge clk);
    a_valid = 1; a_addr = 32'h40; a_wdata = 32'hCAFE_F00D; a_wstrb = 4'hF;
    model_access(32'h40, 32'hCAFE_F00D, 4'hF, rd, e);
    @(posedge clk); #1;
    resetn = 0; a_valid = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_eq("rst_mid_ready", 32'(a_ready), 0);
      check_eq("rst_mid_rdata", a_rdata, 0);
    end
    @(negedge clk); resetn = 1;
    @(posedge clk); #1;
    check_eq("post_rst_ready", 32'(a_ready), 0);
    run_txn(1, 32'h40, 0, 4'h0, 0, 0, 0, 0, got);
    check_eq("rst_write_kept", got, 32'hCAFE_F00D);

    for (int n = 0; n < 150; n++) begin
      bit ae, be;
      ae = ($urandom_range(0, 3) != 0);
      be = ($urandom_range(0, 3) != 0);
      if (!ae && !be) ae = 1;
      run_txn(ae, rand_addr(), $urandom, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
              be, rand_addr(), $urandom, ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom), got);
    end
    for (int i = 0; i < 8; i++) run_txn(1, 32'(i * 4), 0, 4'h0, 0, 0, 0, 0, got);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

`default_nettype wire
